// File: rtl/vx_operands_arb_pkg.sv
// vx_operands_arb_pkg: operands payload layout, field offsets and arbiter state shared by the operand arbiter
package vx_operands_arb_pkg;
  localparam int OP_CNT_W = 4;
  localparam int OP_ID_W = 4;
  localparam int OP_UUID_W = 8;
  localparam int OP_XLEN = 32;
  typedef struct packed {
    logic [OP_UUID_W-1:0] uuid;
    logic [OP_ID_W-1:0] m_instr_id;
    logic [OP_CNT_W-1:0] m_instr_cnt;
    logic [OP_XLEN-1:0] rs1_data;
    logic [OP_XLEN-1:0] rs2_data;
  } data_t;
  localparam int CNT_LSB = 2 * OP_XLEN;
  localparam int ID_LSB = CNT_LSB + OP_CNT_W;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/vx_rr_lock_picker.sv
// vx_rr_lock_picker: masked round-robin pick (eligible, rr_ptr -> one-hot grant, idx) of the first eligible index at or above rr_ptr
module vx_rr_lock_picker #(
  parameter int N = 4,
  localparam int SEL_W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx
);
  logic [N-1:0] hi;
  logic [SEL_W-1:0] idx_hi, idx_lo;
  always_comb begin
    hi = eligible & ~((N'(1) << rr_ptr) - N'(1));
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hi[i]) idx_hi = SEL_W'(i);
      if (eligible[i]) idx_lo = SEL_W'(i);
    end
  end
  assign idx = |hi ? idx_hi : idx_lo;
  assign grant = |eligible ? N'(1) << idx : '0;
endmodule

// File: rtl/vx_operands_arb.sv
// vx_operands_arb: round-robin operand arbiter (valid/data/ready in per source) with matrix-op locking onto a registered valid/ready bus plus locked and stall_cnt status
module vx_operands_arb import vx_operands_arb_pkg::*; #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_W = $bits(data_t),
  parameter int CNT_W = OP_CNT_W,
  localparam int SEL_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_INPUTS-1:0]        valid_in,
  input  logic [NUM_INPUTS*DATA_W-1:0] data_in,
  output logic [NUM_INPUTS-1:0]        ready_in,
  output logic                         valid_out,
  output logic [DATA_W-1:0]            data_out,
  output logic [SEL_W-1:0]             sel_out,
  input  logic                         ready_out,
  output logic                         locked,
  output logic [31:0]                  stall_cnt
);
  arb_state_e state, state_n;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_n, owner, owner_n, idx;
  logic [CNT_W-1:0] remaining, remaining_n, cnt;
  logic [OP_ID_W-1:0] lock_id, lock_id_n, id;
  logic [NUM_INPUTS-1:0] eligible, grant;
  logic [DATA_W-1:0] g_data;
  logic load_en, fire;
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    return int'(i) == NUM_INPUTS - 1 ? '0 : i + SEL_W'(1);
  endfunction
  assign load_en = ~valid_out | ready_out;
  assign eligible = state == LOCKED ? valid_in & (NUM_INPUTS'(1) << owner) : valid_in;
  vx_rr_lock_picker #(.N(NUM_INPUTS)) picker (
    .eligible(eligible),
    .rr_ptr(rr_ptr),
    .grant(grant),
    .idx(idx)
  );
  assign ready_in = load_en ? grant : '0;
  assign fire = |ready_in;
  assign g_data = data_in[int'(idx)*DATA_W +: DATA_W];
  assign cnt = g_data[CNT_LSB +: CNT_W];
  assign id = g_data[ID_LSB +: OP_ID_W];
  assign locked = state == LOCKED;
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    owner_n = owner;
    remaining_n = remaining;
    lock_id_n = lock_id;
    if (fire && state == IDLE && cnt > CNT_W'(1)) begin
      state_n = LOCKED;
      owner_n = idx;
      remaining_n = cnt - CNT_W'(1);
      lock_id_n = id;
    end else if (fire && state == IDLE) begin
      rr_ptr_n = wrap_inc(idx);
    end else if (fire && remaining > CNT_W'(1)) begin
      remaining_n = remaining - CNT_W'(1);
    end else if (fire) begin
      state_n = IDLE;
      remaining_n = '0;
      rr_ptr_n = wrap_inc(owner);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      remaining <= '0;
      lock_id <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
      sel_out <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      owner <= owner_n;
      remaining <= remaining_n;
      lock_id <= lock_id_n;
      if (load_en) valid_out <= fire;
      if (fire) begin
        data_out <= g_data;
        sel_out <= idx;
      end
      if (valid_out && !ready_out && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
  assert property (@(posedge clk) disable iff (!reset_n) (locked && fire) |-> id == lock_id);
endmodule
